// File: rtl/div_restoring_pkg.sv
//==============================================================================
// Module      : div_restoring_pkg
// Description : State encodings and sizing helper shared by the restoring divider.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package div_restoring_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Iteration counter must hold the value N itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_restoring_f_add.sv
//==============================================================================
// Module      : f_ADD
// Description : N-bit adder with carry in/out; used as the divider's trial subtractor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module f_ADD #(
    parameter int N = 65
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_c_in,
    output logic [N-1:0] o_sum,
    output logic         o_c_out
);

    assign {o_c_out, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_c_in};

endmodule

`default_nettype wire

// File: rtl/div_restoring.sv
//==============================================================================
// Module      : div_restoring
// Description : Multi-cycle unsigned restoring divider with valid/ready handshakes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_restoring #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    import div_restoring_pkg::*;

    localparam int c_CNT_W = cnt_width(N);

    logic [1:0]         r_state;
    logic [N-1:0]       r_q;
    logic [N-1:0]       r_d;
    logic [N-1:0]       r_r;
    logic [c_CNT_W-1:0] r_cnt;
    logic [N-1:0]       r_quot;
    logic [N-1:0]       r_rem;
    logic               r_dbz;

    logic [N:0]         w_rs;
    logic [N:0]         w_trial;
    logic               w_c_out;
    logic               w_no_borrow;
    logic [N-1:0]       w_r_next;
    logic [N-1:0]       w_q_next;

    assign w_rs = {r_r, r_q[N-1]};

    f_ADD #(.N(N + 1)) u_trial_sub (
        .i_a     (w_rs),
        .i_b     (~{1'b0, r_d}),
        .i_c_in  (1'b1),
        .o_sum   (w_trial),
        .o_c_out (w_c_out)
    );

    // A non-borrowing trial is always below D, so its top bit is zero.
    assign w_no_borrow = w_c_out & ~w_trial[N];
    assign w_r_next    = w_no_borrow ? w_trial[N-1:0] : w_rs[N-1:0];
    assign w_q_next    = {r_q[N-2:0], w_no_borrow};

    assign in_ready    = (r_state == c_ST_IDLE) & ~rst;
    assign out_valid   = (r_state == c_ST_DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_q   <= dividend;
                        r_d   <= divisor;
                        r_r   <= '0;
                        r_cnt <= c_CNT_W'(N);
                        if (divisor == '0) begin
                            r_state <= c_ST_DONE;
                            r_quot  <= '1;
                            r_rem   <= dividend;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= c_ST_RUN;
                            r_dbz   <= 1'b0;
                        end
                    end
                end
                c_ST_RUN: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= c_ST_DONE;
                        r_quot  <= w_q_next;
                        r_rem   <= w_r_next;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_restoring.sv
//==============================================================================
// Module      : tb_div_restoring
// Description : Directed and randomised self-checking bench for div_restoring.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_div_restoring;

    localparam int N       = 64;
    localparam int c_LIMIT = 200;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_checks;
    int n_errors;

    div_restoring #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for in_ready, then presents one operation for exactly the accept edge.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < c_LIMIT) begin
            @(posedge clk); #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
            n_errors++;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < c_LIMIT) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, in_ready, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            $display("FAIL reset_state: ov=%b ir=%b dbz=%b q=%h r=%h required all zero",
                     out_valid, in_ready, div_by_zero, quotient, remainder);
            n_errors++;
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
            n_errors++;
        end
    endtask

    task automatic test_basic();
        int cyc;
        issue(64'd100, 64'd7);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL basic_busy: in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
            n_errors++;
        end
        wait_result(cyc);
        n_checks++;
        if (cyc !== 64) begin
            $display("FAIL basic_latency: cycles=%0d required 64", cyc);
            n_errors++;
        end
        n_checks++;
        if (quotient !== 64'd14 || remainder !== 64'd2 || div_by_zero !== 1'b0) begin
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b required 14/2/0",
                     quotient, remainder, div_by_zero);
            n_errors++;
        end
        consume();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL basic_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
            n_errors++;
        end
    endtask

    task automatic test_vectors();
        logic [N-1:0] va [4];
        logic [N-1:0] vb [4];
        logic [N-1:0] vq [4];
        logic [N-1:0] vr [4];
        int cyc;
        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'd1;
        vq[0] = 64'hFFFF_FFFF_FFFF_FFFF; vr[0] = 64'd0;
        va[1] = 64'd3;                   vb[1] = 64'd10;
        vq[1] = 64'd0;                   vr[1] = 64'd3;
        va[2] = 64'hFFFF_FFFF_FFFF_FFFF; vb[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        vq[2] = 64'd1;                   vr[2] = 64'd0;
        va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'd3;
        vq[3] = 64'h2AAA_AAAA_AAAA_AAAA; vr[3] = 64'd2;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i]);
            wait_result(cyc);
            n_checks++;
            if (cyc !== 64 || quotient !== vq[i] || remainder !== vr[i] || div_by_zero !== 1'b0) begin
                $display("FAIL vector_%0d: cyc=%0d q=%h r=%h dbz=%b required 64 q=%h r=%h dbz=0",
                         i, cyc, quotient, remainder, div_by_zero, vq[i], vr[i]);
                n_errors++;
            end
            consume();
        end
    endtask

    task automatic test_div_by_zero();
        int cyc;
        issue(64'd5, 64'd0);
        wait_result(cyc);
        n_checks++;
        if (cyc !== 0) begin
            $display("FAIL dbz_latency: cycles=%0d required 0", cyc);
            n_errors++;
        end
        n_checks++;
        if (div_by_zero !== 1'b1 || quotient !== 64'hFFFF_FFFF_FFFF_FFFF || remainder !== 64'd5) begin
            $display("FAIL dbz_result: dbz=%b q=%h r=%0d required 1/all-ones/5",
                     div_by_zero, quotient, remainder);
            n_errors++;
        end
        consume();
    endtask

    task automatic test_backpressure();
        int cyc;
        issue(64'd9, 64'd2);
        wait_result(cyc);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            dividend = 64'd77 + 64'(i);
            divisor  = 64'(i);
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 64'd4 ||
                remainder !== 64'd1 || div_by_zero !== 1'b0) begin
                $display("FAIL backpressure_%0d: ov=%b ir=%b q=%0d r=%0d dbz=%b required 1/0/4/1/0",
                         i, out_valid, in_ready, quotient, remainder, div_by_zero);
                n_errors++;
            end
        end
        in_valid = 1'b0;
        consume();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL backpressure_release: ov=%b ir=%b required 0/1", out_valid, in_ready);
            n_errors++;
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int seen;
        issue(64'd12345, 64'd7);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL abort_release: ir=%b ov=%b required 1/0", in_ready, out_valid);
            n_errors++;
        end
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            $display("FAIL abort_no_valid: out_valid cycles=%0d required 0", seen);
            n_errors++;
        end
        issue(64'd1000, 64'd33);
        wait_result(cyc);
        n_checks++;
        if (cyc !== 64 || quotient !== 64'd30 || remainder !== 64'd10) begin
            $display("FAIL abort_followup: cyc=%0d q=%0d r=%0d required 64/30/10", cyc, quotient, remainder);
            n_errors++;
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] eq;
        logic [N-1:0] er;
        logic         ez;
        int cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom} >> $urandom_range(0, 40);
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 49) == 0) b = '0;
            if (b == '0) begin
                eq = '1; er = a; ez = 1'b1;
            end else begin
                eq = a / b; er = a % b; ez = 1'b0;
            end
            issue(a, b);
            wait_result(cyc);
            n_checks++;
            if (out_valid !== 1'b1 || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                $display("FAIL random_%0d: %h/%h ov=%b q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                         i, a, b, out_valid, quotient, remainder, div_by_zero, eq, er, ez);
                n_errors++;
            end
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        test_reset();
        test_basic();
        test_vectors();
        test_div_by_zero();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
